// File: rtl/fifo_tc_pkg.sv
// Shared defaults for the per-traffic-class FIFOs and the downstream 2:1 mux,
// so every instance agrees on word width, depth and flag thresholds.
package fifo_tc_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 6;
    localparam int unsigned DEF_ADDR_WIDTH   = 2;
    localparam int unsigned DEF_ALMOST_FULL  = 3;
    localparam int unsigned DEF_ALMOST_EMPTY = 1;

endpackage : fifo_tc_pkg

// File: rtl/fifo_tc_mem.sv
// fifo_mem: depth x DATA_WIDTH register array, synchronous write port and
// combinational read port. Contents are deliberately not reset.
module fifo_mem
    import fifo_tc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: single-entry write when enabled
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register, no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/fifo_tc.sv
// fifo_tc: per-traffic-class input FIFO feeding the 2:1 6-bit mux. Registered
// word/valid output per accepted pop, count-decoded fill flags, sticky error.
module fifo_tc
    import fifo_tc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned ALMOST_FULL  = DEF_ALMOST_FULL,
    parameter int unsigned ALMOST_EMPTY = DEF_ALMOST_EMPTY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int unsigned   DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned   CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  error_q, error_d;
    logic                  push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    // Accept decisions, pointer/count/output/error next-state
    always_comb begin
        // Pop is judged on the pre-edge count only: a push into an empty
        // FIFO is never forwarded to the output in the same cycle.
        pop_ok      = pop && (count_q != '0);
        push_ok     = push && ((count_q != CNT_FULL) || pop_ok);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        error_d     = error_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d  = rd_word;
            valid_out_d = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if ((push && !push_ok) || (pop && !pop_ok)) begin
            error_d = 1'b1;
        end
    end

    // State registers, asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign error        = error_q;
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(ALMOST_FULL));
    assign almost_empty = (count_q <= CW'(ALMOST_EMPTY));

endmodule : fifo_tc

// File: tb/tb_fifo_tc.sv
// Directed self-checking bench for fifo_tc with hand-computed expectations.
module tb_fifo_tc;

    logic       clk;
    logic       reset;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    int unsigned n_checks;
    int unsigned n_fails;

    fifo_tc #(
        .DATA_WIDTH   (6),
        .ADDR_WIDTH   (2),
        .ALMOST_FULL  (3),
        .ALMOST_EMPTY (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count and report
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic e_full, input logic e_empty,
                               input logic e_af, input logic e_ae);
        check({tag, ".full"},         full,         e_full);
        check({tag, ".empty"},        empty,        e_empty);
        check({tag, ".almost_full"},  almost_full,  e_af);
        check({tag, ".almost_empty"}, almost_empty, e_ae);
    endtask

    // Reset asserted mid-cycle, held across one edge, released mid-cycle
    task automatic do_reset();
        #3;
        reset = 1'b1;
        step();
        #3;
        reset = 1'b0;
        #1;
    endtask

    logic [5:0] pre [4];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = '0;
        pre[0] = 6'h10; pre[1] = 6'h11; pre[2] = 6'h12; pre[3] = 6'h13;

        repeat (2) step();
        reset = 1'b0;

        // Idle after reset
        repeat (3) step();
        check("rst.valid_out", valid_out, 1'b0);
        check("rst.data_out",  data_out,  6'h00);
        check("rst.error",     error,     1'b0);
        check_flags("rst", 1'b0, 1'b1, 1'b0, 1'b1);

        // Fill 1..4, flags track count
        for (int i = 1; i <= 4; i++) begin
            push = 1'b1; data_in = 6'(i);
            step();
            check_flags($sformatf("fill%0d", i), (i == 4), 1'b0, (i >= 3), (i <= 1));
            check($sformatf("fill%0d.valid", i), valid_out, 1'b0);
        end
        push = 1'b0;

        // Drain 1..4 in order
        for (int i = 1; i <= 4; i++) begin
            pop = 1'b1;
            step();
            check($sformatf("drain%0d.data", i),  data_out,  6'(i));
            check($sformatf("drain%0d.valid", i), valid_out, 1'b1);
            check($sformatf("drain%0d.empty", i), empty,     (i == 4));
        end
        pop = 1'b0;
        step();
        check("drain.idle_valid", valid_out, 1'b0);
        check("drain.hold_data",  data_out,  6'h04);
        check("drain.error",      error,     1'b0);

        // Overflow: refill, push 0x3F while full, word must be dropped
        for (int i = 1; i <= 4; i++) begin
            push = 1'b1; data_in = 6'(i);
            step();
        end
        data_in = 6'h3F;
        step();
        push = 1'b0;
        check("ovf.error", error, 1'b1);
        check("ovf.full",  full,  1'b1);
        for (int i = 1; i <= 4; i++) begin
            pop = 1'b1;
            step();
            check($sformatf("ovf_drain%0d.data", i),  data_out,  6'(i));
            check($sformatf("ovf_drain%0d.valid", i), valid_out, 1'b1);
        end
        pop = 1'b0;
        step();
        check("ovf.empty_after", empty, 1'b1);
        check("ovf.idle_valid",  valid_out, 1'b0);

        // Full with simultaneous push/pop for 6 cycles; pointers wrap
        do_reset();
        check("rst2.error", error, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; data_in = pre[i];
            step();
        end
        for (int k = 0; k < 6; k++) begin
            push = 1'b1; pop = 1'b1; data_in = 6'h2A + 6'(k);
            step();
            check($sformatf("pp%0d.data", k),  data_out,  (k < 4) ? pre[k] : 6'h2A + 6'(k - 4));
            check($sformatf("pp%0d.valid", k), valid_out, 1'b1);
            check($sformatf("pp%0d.full", k),  full,      1'b1);
            check($sformatf("pp%0d.error", k), error,     1'b0);
        end
        push = 1'b0;
        for (int k = 2; k < 6; k++) begin
            pop = 1'b1;
            step();
            check($sformatf("pp_drain%0d.data", k), data_out, 6'h2A + 6'(k));
        end
        pop = 1'b0;
        step();
        check_flags("pp.end", 1'b0, 1'b1, 1'b0, 1'b1);
        check("pp.end_error", error, 1'b0);

        // Empty with simultaneous push/pop: push taken, pop rejected
        push = 1'b1; pop = 1'b1; data_in = 6'h15;
        step();
        check("ep.valid", valid_out, 1'b0);
        check("ep.error", error,     1'b1);
        check("ep.data_hold", data_out, 6'h2F);
        check_flags("ep", 1'b0, 1'b0, 1'b0, 1'b1);
        push = 1'b0;
        step();
        check("ep_pop.data",  data_out,  6'h15);
        check("ep_pop.valid", valid_out, 1'b1);
        check("ep_pop.empty", empty,     1'b1);
        pop = 1'b0;

        // Asynchronous reset mid-pop-burst
        do_reset();
        check("rst3.error", error, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; data_in = 6'h07 + 6'(i);
            step();
        end
        push = 1'b0; pop = 1'b1;
        step();
        check("ar.pre_data",  data_out,  6'h07);
        check("ar.pre_valid", valid_out, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("ar.data",  data_out,  6'h00);
        check("ar.valid", valid_out, 1'b0);
        check_flags("ar", 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        #3;
        reset = 1'b0;
        step();
        check("ar_pop.valid", valid_out, 1'b0);
        check("ar_pop.data",  data_out,  6'h00);
        check("ar_pop.error", error,     1'b1);
        check("ar_pop.empty", empty,     1'b1);
        pop = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_fifo_tc
